// File: rtl/fifth_uart_tx_io_pkg.sv
// Shared definitions for the fifth CPU I/O peripherals: register indices,
// STATUS bit positions and the UART transmit serialiser state encoding.
package fifth_io_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/fifth_uart_tx_io_fifo.sv
// fifth_sync_fifo: synchronous FIFO with count; a push is accepted when full
// only if a pop frees a slot on the same edge.
module fifth_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fifth_uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the fifth CPU data bus.
// Define FIFTH_UART_OVF_EN to build the sticky STATUS overflow flag.
module fifth_uart_tx_io
    import fifth_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic        bus_we,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_sel,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic [15:0] div_q;

    logic        sel_s, wr_s, push_s, pop_s, bit_done_s;
    logic        full_s, empty_s, ovf_s;
    logic [1:0]  idx_s;
    logic [7:0]  fifo_rdata_s;
    logic [CW-1:0] count_s;
    logic [15:0] status_s;

    assign sel_s      = (bus_addr[15:2] == BASE_ADDR[15:2]);
    assign idx_s      = bus_addr[1:0];
    assign wr_s       = sel_s & bus_we;
    assign push_s     = wr_s & (idx_s == REG_TXDATA);
    assign bit_done_s = (cnt_q == div_q);
    assign pop_s      = ~empty_s & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_done_s));
    assign bus_sel    = sel_s;
    assign tx         = tx_q;

    fifth_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (bus_wdata[7:0]),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Bit timing compares against the live divider, so a mid-frame change applies at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            cnt_q    <= 16'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 16'd0;
                    if (!empty_s) begin
                        shift_q <= fifo_rdata_s;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_done_s) begin
                        cnt_q    <= 16'd0;
                        bitcnt_q <= 3'd0;
                        tx_q     <= shift_q[0];
                        state_q  <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done_s) begin
                        cnt_q <= 16'd0;
                        if (bitcnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done_s) begin
                        cnt_q <= 16'd0;
                        if (!empty_s) begin
                            shift_q <= fifo_rdata_s;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    cnt_q   <= 16'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
        end else if (wr_s && (idx_s == REG_BAUDDIV)) begin
            div_q <= bus_wdata;
        end
    end

`ifdef FIFTH_UART_OVF_EN
    logic ovf_q, ovf_set_s, ovf_clr_s;
    assign ovf_set_s = push_s & full_s & ~pop_s;
    assign ovf_clr_s = wr_s & (idx_s == REG_STATUS) & bus_wdata[ST_OVF];
    assign ovf_s     = ovf_q;

    // A set wins over a clear arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set_s | (ovf_q & ~ovf_clr_s);
        end
    end
`else
    assign ovf_s = 1'b0;
`endif

    always_comb begin
        status_s                        = 16'd0;
        status_s[ST_FULL]               = full_s;
        status_s[ST_EMPTY]              = empty_s;
        status_s[ST_BUSY]               = (state_q != S_IDLE);
        status_s[ST_OVF]                = ovf_s;
        status_s[ST_CNT_MSB:ST_CNT_LSB] = 5'(count_s);
    end

    always_comb begin
        bus_rdata = 16'd0;
        if (sel_s) begin
            case (idx_s)
                REG_STATUS:  bus_rdata = status_s;
                REG_BAUDDIV: bus_rdata = div_q;
                default:     bus_rdata = 16'd0;
            endcase
        end else begin
            bus_rdata = 16'd0;
        end
    end

endmodule

// File: tb/tb_fifth_uart_tx_io.sv
// Self-checking bench for fifth_uart_tx_io: register table, directed frame
// sequences and randomized traffic against a frame-level reference model.
module tb_fifth_uart_tx_io;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bus_addr = 16'h0000;
    logic        bus_we = 1'b0;
    logic [15:0] bus_wdata = 16'h0000;
    logic [15:0] bus_rdata;
    logic        bus_sel;
    logic        tx;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes waiting, the frame on the line and clocks into it.
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_fb = 8'h00;
    int         m_period = 434;
    bit         m_ovf = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_sel;
    } vec_t;
    vec_t vecs[10];

    fifth_uart_tx_io dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_sel   (bus_sel),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / m_period;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_fb[k-1];
    endfunction

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s = 16'h0000;
        s[0] = (mq.size() == DEPTH);
        s[1] = (mq.size() == 0);
        s[2] = m_active;
`ifdef FIFTH_UART_OVF_EN
        s[3] = m_ovf;
`endif
        s[8:4] = 5'(mq.size());
        return s;
    endfunction

    task automatic model_edge(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        if (m_active) begin
            if (m_t == 10 * m_period - 1) begin
                if (mq.size() > 0) begin
                    m_fb = mq.pop_front();
                    m_t = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
            end
        end else if (mq.size() > 0) begin
            m_fb = mq.pop_front();
            m_t = 0;
            m_active = 1'b1;
        end
        if (we && (addr[15:2] == 14'h3FC0)) begin
            case (addr[1:0])
                2'd0: if (mq.size() < DEPTH) mq.push_back(wd[7:0]); else m_ovf = 1'b1;
                2'd1: if (wd[3]) m_ovf = 1'b0;
                2'd2: m_period = int'(wd) + 1;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        @(negedge clk);
        bus_we = we;
        bus_addr = addr;
        bus_wdata = wd;
        @(posedge clk);
        model_edge(we, addr, wd);
        #1;
        bus_we = 1'b0;
        bus_addr = 16'hFF01;
        #1;
        check("tx", 32'(tx), 32'(exp_tx()));
        check("status", 32'(bus_rdata), 32'(exp_status()));
    endtask

    task automatic idle();
        step(1'b0, 16'hFF01, 16'h0000);
    endtask

    initial begin
        logic [9:0] bits;
        int n;
        logic [15:0] exp_full;

        vecs[0] = '{16'hFF02, 1'b1, 16'h0005, 16'h0005, 1'b1};
        vecs[1] = '{16'hFF03, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
        vecs[2] = '{16'hFF06, 1'b1, 16'h1234, 16'h0000, 1'b0};
        vecs[3] = '{16'hFF02, 1'b0, 16'h0000, 16'h0005, 1'b1};
        vecs[4] = '{16'hFF00, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{16'hFF01, 1'b1, 16'hFFFF, 16'h0002, 1'b1};
        vecs[6] = '{16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[7] = '{16'hFEFF, 1'b1, 16'h0001, 16'h0000, 1'b0};
        vecs[8] = '{16'hFF02, 1'b1, 16'hBEEF, 16'hBEEF, 1'b1};
        vecs[9] = '{16'hFF02, 1'b1, 16'h0003, 16'h0003, 1'b1};

        // Reset state
        #12;
        check("reset_tx", 32'(tx), 32'h1);
        bus_addr = 16'hFF01; #1;
        check("reset_status", 32'(bus_rdata), 32'h0002);
        bus_addr = 16'hFF02; #1;
        check("reset_bauddiv", 32'(bus_rdata), 32'd433);
        bus_addr = 16'h0000; #1;
        check("unsel_rdata", 32'(bus_rdata), 32'h0);
        check("unsel_sel", 32'(bus_sel), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Register access table
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            bus_addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_rdata", i), 32'(bus_rdata), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_sel", i), 32'(bus_sel), 32'(vecs[i].exp_sel));
        end

        // 8'hA5 at BAUDDIV=3: sample mid-bit
        step(1'b1, 16'hFF02, 16'd3);
        step(1'b1, 16'hFF00, 16'h00A5);
        bits = 10'h000;
        for (int i = 0; i < 41; i++) begin
            idle();
            if (i < 40 && (i % 4) == 1) bits[i/4] = tx;
        end
        check("a5_frame_bits", 32'(bits), 32'h34A);

        // Back-to-back frames at BAUDDIV=0
        step(1'b1, 16'hFF02, 16'd0);
        step(1'b1, 16'hFF00, 16'h0011);
        step(1'b1, 16'hFF00, 16'h00C3);
        step(1'b1, 16'hFF00, 16'h007E);
        for (int i = 0; i < 30; i++) idle();

        // Overflow: ten writes into an 8-deep FIFO at BAUDDIV=100
        step(1'b1, 16'hFF02, 16'd100);
        for (int i = 0; i < 10; i++) step(1'b1, 16'hFF00, 16'h0000);
        exp_full = 16'h0085;
`ifdef FIFTH_UART_OVF_EN
        exp_full = 16'h008D;
`endif
        check("full_after_10", 32'(bus_rdata), 32'(exp_full));
        step(1'b1, 16'hFF01, 16'h0008);
        check("ovf_cleared", 32'(bus_rdata), 32'h0085);

        // Push on the same edge as the end-of-frame pop while full
        n = 0;
        while (!(m_active && m_t == 10 * m_period - 1) && n < 2000) begin
            idle();
            n++;
        end
        check("pop_edge_reached", 32'(n < 2000), 32'h1);
        step(1'b1, 16'hFF00, 16'h003C);
        check("push_at_pop_full", 32'(bus_rdata), 32'h0085);

        // Asynchronous reset mid-DATA
        n = 0;
        while (!(m_active && m_t == 3 * m_period + 50) && n < 2000) begin
            idle();
            n++;
        end
        check("mid_data_reached", 32'(n < 2000), 32'h1);
        check("mid_data_tx_low", 32'(tx), 32'h0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx), 32'h1);
        check("async_reset_status", 32'(bus_rdata), 32'h0002);
        bus_addr = 16'hFF02; #1;
        check("async_reset_div", 32'(bus_rdata), 32'd433);
        mq.delete();
        m_active = 1'b0;
        m_t = 0;
        m_period = 434;
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) idle();
        check("no_resume", 32'(bus_rdata), 32'h0002);

        // Randomized traffic, several divider settings
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 16'hFF02, 16'($urandom_range(0, 3)));
            for (int i = 0; i < 300; i++) begin
                n = $urandom_range(0, 9);
                if (n < 4)       step(1'b1, 16'hFF00, 16'($urandom_range(0, 255)));
                else if (n == 4) step(1'b1, 16'hFF01, 16'($urandom));
                else if (n == 5) step(1'b1, 16'hFF03, 16'($urandom));
                else             idle();
            end
            n = 0;
            while ((m_active || mq.size() > 0) && n < 2000) begin
                idle();
                n++;
            end
            check("random_drain", 32'(n < 2000), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifth_uart_tx_io.md
Name: fifth_uart_tx_io

Overview:
- Memory-mapped UART transmit peripheral; the responder on the fifth CPU data-memory bus (mem_address / mem_write_enable / mem_data_output / mem_data_input).
- CPU stores bytes into a TX FIFO; an 8N1 serialiser drains the FIFO onto the tx pin.
- Status and baud-divider registers are readable so firmware can poll before storing.
- Sits beside data RAM; the top-level muxes bus_rdata into the CPU's mem_data_input when bus_sel is high.

Parameters:
- BASE_ADDR, 16'hFF00, word address of register 0; must be 4-aligned (bits [1:0] = 0).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.
- DEFAULT_DIV, 16'd433, reset value of BAUDDIV; bit period is BAUDDIV+1 clocks.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  16  CPU data address (mem_address).
- bus_we  in  1  CPU write strobe (mem_write_enable).
- bus_wdata  in  16  CPU store data (mem_data_output).
- bus_rdata  out  16  combinational read data; 0 when not selected.
- bus_sel  out  1  high when bus_addr[15:2] == BASE_ADDR[15:2].
- tx  out  1  serial line, idle high, registered.

Behaviour:
- Register map (index = bus_addr[1:0]):
  - 0 TXDATA: write pushes bus_wdata[7:0]; reads 0.
  - 1 STATUS: read-only except bit3.
    - bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 overflow (see optional feature).
    - bits[8:4] FIFO count; remaining bits 0.
  - 2 BAUDDIV: read/write, 16-bit.
  - 3 reserved: reads 0, writes ignored.
- Reads are combinational from current register state, with no wait states.
- Writes take effect only when bus_sel & bus_we, at the rising edge.
- Reset, applied immediately and asynchronously:
  - tx = 1, state = IDLE, FIFO empty, BAUDDIV = DEFAULT_DIV, overflow = 0.
  - A frame in progress is abandoned; no partial frame resumes after reset.
- FIFO:
  - Write to TXDATA when not full: push.
  - Write to TXDATA when full: drop the byte and leave the FIFO unchanged.
  - Push and pop on the same edge with the FIFO full: the pop frees a slot and the push is accepted (count unchanged).
  - Pointers wrap modulo FIFO_DEPTH.
  - Count saturates at FIFO_DEPTH and never underflows.
- Serialiser states: IDLE -> START -> DATA -> STOP -> IDLE/START.
  - IDLE: tx=1. If FIFO non-empty, pop into shift register, go to START, tx=0 from that edge.
  - START: hold tx=0 for one bit period, then DATA.
  - DATA: 8 bits LSB first, one bit period each; 3-bit bit counter.
  - STOP: tx=1 for one bit period. At the end, go to START if FIFO non-empty (back-to-back frames, no idle gap), else IDLE.
  - Bit period: a 16-bit counter counts 0..BAUDDIV, and the bit advances when counter == BAUDDIV. BAUDDIV=0 gives a 1-clock bit.
- Latency: a TXDATA write at edge E0 with the FIFO empty and the serialiser IDLE pulls tx low at edge E1.
- BAUDDIV writes mid-frame: the counter compares against the live register, so a new value applies within the current bit.
  - Writing a value below the current count makes that bit run until the 16-bit counter wraps. Firmware must only change BAUDDIV while busy=0.
- CPU reset pulses only through the system reset; the block has no dependence on the CPU's internal reboot state.

Optional Feature:
- Macro: FIFTH_UART_OVF_EN.
- Defined:
  - A write to TXDATA while full (and not simultaneously popped) sets sticky STATUS bit3.
  - Writing STATUS with bus_wdata[3]=1 clears it; a set and a clear on the same edge leaves it set.
- Undefined: bit3 reads 0, STATUS writes are ignored, and no overflow flop is built. Drop behaviour is identical either way.

Decomposition:
- Shared package fifth_io_pkg holds:
  - register index constants (REG_TXDATA=0, REG_STATUS=1, REG_BAUDDIV=2);
  - STATUS bit positions;
  - the serialiser state enum.
- One natural sub-module: fifth_sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable for a future RX block.

Test Plan:
- Reset -> tx=1, STATUS read = 16'h0002, BAUDDIV read = 433, bus_rdata=0 at address 16'h0000.
- BAUDDIV=3, write 8'hA5 to 16'hFF00 -> tx low from the next edge. Bits at 4-clock spacing are 0,1,0,1,0,0,1,0,1, then stop 1. Frame = 40 clocks, then busy=0.
- BAUDDIV=0, write 3 bytes back-to-back -> 30 contiguous bit clocks, no idle gap; count reads 2 then 1 then 0 as each frame starts.
- FIFO_DEPTH=8, BAUDDIV=100, 10 writes -> first byte popped, 8 queued, full=1, tenth dropped. With FIFTH_UART_OVF_EN: STATUS bit3=1; writing STATUS 16'h0008 clears it.
- Write while full on the same edge the serialiser pops -> accepted, count stays 8, no overflow.
- Assert reset mid-DATA -> tx=1 asynchronously, FIFO empty, state IDLE; no frame resumes after release.
